// File: rtl/conv_window_sequencer_if.sv
// Handshake bundle for conv_window_sequencer: start/kernel, pixel stream, result stream, status.
// master = pixel source / result sink side, slave = sequencer side.
interface conv_window_sequencer_if #(
    parameter int b = 8,
    parameter int c = 3
);
    logic               start;
    logic [c*c*b-1:0]   inp_kernel;
    logic               pix_valid;
    logic               pix_ready;
    logic [b-1:0]       pix_data;
    logic               out_valid;
    logic               out_ready;
    logic [b-1:0]       out_data;
    logic               busy;
    logic               done;

    modport master (
        output start, inp_kernel, pix_valid, pix_data, out_ready,
        input  pix_ready, out_valid, out_data, busy, done
    );

    modport slave (
        input  start, inp_kernel, pix_valid, pix_data, out_ready,
        output pix_ready, out_valid, out_data, busy, done
    );
endinterface

// File: rtl/conv_window_sequencer.sv
// Frame-buffered valid convolution, one MAC per cycle, results streamed row-major.
// Optional macro CONV_SAT_EN: saturate results to 2^b-1 instead of truncating.
module conv_window_sequencer #(
    parameter int b = 8,
    parameter int a = 5,
    parameter int c = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    conv_window_sequencer_if.slave  bus
);
    localparam int AW   = (a > 1) ? $clog2(a) : 1;
    localparam int CW   = (c > 1) ? $clog2(c) : 1;
    localparam int FN   = a * a;
    localparam int FW   = (FN > 1) ? $clog2(FN) : 1;
    localparam int ACCW = 2 * b + c + 1;
    localparam logic [AW-1:0] A_LAST   = AW'(a - 1);
    localparam logic [AW-1:0] WIN_LAST = AW'(a - c);
    localparam logic [CW-1:0] C_LAST   = CW'(c - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_EMIT, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [b-1:0]       r_frame [FN];
    logic [c*c*b-1:0]   r_kernel;
    logic [AW-1:0]      r_r, r_q, r_wr, r_wc;
    logic [CW-1:0]      r_ki, r_kj;
    logic [ACCW-1:0]    r_acc;
    logic [b-1:0]       r_out_data;

    logic               w_pix_fire, w_out_fire, w_last_pix, w_k_last, w_win_last;
    logic [FW-1:0]      w_load_idx, w_read_idx;
    logic [31:0]        w_ker_idx;
    logic [b-1:0]       w_pix_sel, w_ker_sel;
    logic [ACCW-1:0]    w_acc_next;
    logic [b-1:0]       w_result;

    assign w_pix_fire = (r_state == S_LOAD) && bus.pix_valid;
    assign w_out_fire = (r_state == S_EMIT) && bus.out_ready;
    assign w_last_pix = (r_r == A_LAST) && (r_q == A_LAST);
    assign w_k_last   = (r_ki == C_LAST) && (r_kj == C_LAST);
    assign w_win_last = (r_wr == WIN_LAST) && (r_wc == WIN_LAST);

    assign w_load_idx = FW'(32'(r_r) * a + 32'(r_q));
    assign w_read_idx = FW'((32'(r_wr) + 32'(r_ki)) * a + 32'(r_wc) + 32'(r_kj));
    assign w_ker_idx  = 32'(r_ki) * c + 32'(r_kj);
    assign w_pix_sel  = r_frame[w_read_idx];
    assign w_ker_sel  = r_kernel[w_ker_idx*b +: b];

    // First product of each window restarts the accumulator
    assign w_acc_next = (((r_ki == '0) && (r_kj == '0)) ? '0 : r_acc)
                      + ACCW'(w_pix_sel) * ACCW'(w_ker_sel);

`ifdef CONV_SAT_EN
    assign w_result = (|w_acc_next[ACCW-1:b]) ? '1 : w_acc_next[b-1:0];
`else
    assign w_result = w_acc_next[b-1:0];
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (bus.start) w_state_next = S_LOAD;
            S_LOAD:    if (w_pix_fire && w_last_pix) w_state_next = S_COMPUTE;
            S_COMPUTE: if (w_k_last) w_state_next = S_EMIT;
            S_EMIT:    if (w_out_fire) w_state_next = w_win_last ? S_DONE : S_COMPUTE;
            S_DONE:    w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Frame store has no reset: a new frame always overwrites every entry before use
    always_ff @(posedge clk) begin
        if (w_pix_fire) r_frame[w_load_idx] <= bus.pix_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_kernel   <= '0;
            r_r        <= '0;
            r_q        <= '0;
            r_wr       <= '0;
            r_wc       <= '0;
            r_ki       <= '0;
            r_kj       <= '0;
            r_acc      <= '0;
            r_out_data <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_kernel <= bus.inp_kernel;
                        r_r      <= '0;
                        r_q      <= '0;
                        r_wr     <= '0;
                        r_wc     <= '0;
                        r_ki     <= '0;
                        r_kj     <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_pix_fire) begin
                        if (r_q == A_LAST) begin
                            r_q <= '0;
                            r_r <= r_r + 1'b1;
                        end else begin
                            r_q <= r_q + 1'b1;
                        end
                    end
                end
                S_COMPUTE: begin
                    r_acc <= w_acc_next;
                    if (r_kj == C_LAST) begin
                        r_kj <= '0;
                        r_ki <= (r_ki == C_LAST) ? '0 : r_ki + 1'b1;
                    end else begin
                        r_kj <= r_kj + 1'b1;
                    end
                    if (w_k_last) r_out_data <= w_result;
                end
                S_EMIT: begin
                    if (w_out_fire && !w_win_last) begin
                        if (r_wc == WIN_LAST) begin
                            r_wc <= '0;
                            r_wr <= r_wr + 1'b1;
                        end else begin
                            r_wc <= r_wc + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pix_ready = (r_state == S_LOAD);
    assign bus.out_valid = (r_state == S_EMIT);
    assign bus.out_data  = r_out_data;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);
endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer: directed vector table, hand-written corner sequences,
// and random frames checked against a direct arithmetic convolution model.
module tb_conv_window_sequencer;
    localparam int B = 8;
    localparam int A = 5;
    localparam int C = 3;
    localparam int NW = (A - C + 1) * (A - C + 1);

    logic clk;
    logic rst;
    conv_window_sequencer_if #(.b(B), .c(C)) bus ();

    conv_window_sequencer #(.b(B), .a(A), .c(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int cur_pix [A*A];
    int cur_ker [C*C];
    int cur_exp [NW];

    typedef struct packed {
        logic [1:0]        pix_kind;   // 0 ones, 1 ramp, 2 all 255
        logic [1:0]        ker_kind;   // 0 ones, 1 centre only, 2 all 255
        logic [3:0]        gap;        // idle cycles before each pixel
        logic              noise;      // start pulses / junk data during gaps
        logic [8:0][7:0]   exp;        // expected results, index 0 first
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [C*C*B-1:0] pack_kernel();
        logic [C*C*B-1:0] k;
        k = '0;
        for (int i = 0; i < C*C; i++) k[i*B +: B] = B'(cur_ker[i]);
        return k;
    endfunction

    // Direct definition of a valid convolution, evaluated window by window
    task automatic model();
        for (int wr = 0; wr <= A - C; wr++)
            for (int wc = 0; wc <= A - C; wc++) begin
                longint sum = 0;
                for (int i = 0; i < C; i++)
                    for (int j = 0; j < C; j++)
                        sum += longint'(cur_pix[(wr+i)*A + wc + j]) * longint'(cur_ker[i*C + j]);
`ifdef CONV_SAT_EN
                cur_exp[wr*(A-C+1) + wc] = (sum > 255) ? 255 : int'(sum);
`else
                cur_exp[wr*(A-C+1) + wc] = int'(sum % 256);
`endif
            end
    endtask

    task automatic send_start();
        // a stray pixel while idle must not be taken
        @(negedge clk);
        bus.pix_valid = 1'b1;
        bus.pix_data  = 8'hA5;
        check("idle_pix_ready", int'(bus.pix_ready), 0);
        @(negedge clk);
        bus.pix_valid  = 1'b0;
        bus.inp_kernel = pack_kernel();
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", int'(bus.busy), 1);
    endtask

    task automatic load_frame(input int gap, input bit noise);
        for (int p = 0; p < A*A; p++) begin
            for (int g = 0; g < gap; g++) begin
                bus.pix_valid = 1'b0;
                bus.pix_data  = B'($urandom);
                if (noise) begin
                    bus.start      = 1'b1;
                    bus.inp_kernel = {$urandom, $urandom, $urandom};
                end
                @(negedge clk);
                bus.start = 1'b0;
            end
            bus.pix_valid = 1'b1;
            bus.pix_data  = B'(cur_pix[p]);
            check("pix_ready", int'(bus.pix_ready), 1);
            @(negedge clk);
        end
        bus.pix_valid = 1'b0;
    endtask

    // Entered one cycle after the previous handshake (or last pixel); returns likewise.
    task automatic get_result(input int stall, input bit ready_noise, output int val);
        int lat = 1;
        logic [B-1:0] held;
        while (!bus.out_valid && lat < 40) begin
            bus.out_ready = ready_noise ? 1'($urandom) : 1'b0;
            @(negedge clk);
            lat++;
        end
        bus.out_ready = 1'b0;
        check("latency", lat, C*C + 1);
        val = -1;
        if (bus.out_valid) begin
            held = bus.out_data;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                check("hold_valid", int'(bus.out_valid), 1);
                check("hold_data", int'(bus.out_data), int'(held));
            end
            val = int'(bus.out_data);
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic run_frame(input string tag, input int gap, input bit noise,
                             input int stall0, input int max_stall);
        int v;
        send_start();
        load_frame(gap, noise);
        for (int w = 0; w < NW; w++) begin
            get_result((w == 0) ? stall0 : int'($urandom_range(max_stall, 0)), max_stall > 0, v);
            $display("%s window %0d: out_data=%0d expect=%0d", tag, w, v, cur_exp[w]);
            check("result", v, cur_exp[w]);
        end
        check("done_pulse", int'(bus.done), 1);
        check("busy_in_done", int'(bus.busy), 1);
        @(negedge clk);
        check("done_clear", int'(bus.done), 0);
        check("busy_clear", int'(bus.busy), 0);
    endtask

    task automatic set_kind(input logic [1:0] pk, input logic [1:0] kk);
        for (int p = 0; p < A*A; p++) cur_pix[p] = (pk == 0) ? 1 : (pk == 1) ? p : 255;
        for (int k = 0; k < C*C; k++) cur_ker[k] = (kk == 0) ? 1 : (kk == 1) ? ((k == 4) ? 1 : 0) : 255;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs [4];
        logic [7:0] sat9;
        int v;
`ifdef CONV_SAT_EN
        sat9 = 8'hFF;
`else
        sat9 = 8'h09;
`endif
        vecs[0] = '{pix_kind: 2'd0, ker_kind: 2'd0, gap: 4'd0, noise: 1'b0, exp: {9{8'd9}}};
        vecs[1] = '{pix_kind: 2'd1, ker_kind: 2'd1, gap: 4'd0, noise: 1'b0,
                    exp: {8'd18, 8'd17, 8'd16, 8'd13, 8'd12, 8'd11, 8'd8, 8'd7, 8'd6}};
        vecs[2] = '{pix_kind: 2'd2, ker_kind: 2'd2, gap: 4'd0, noise: 1'b0, exp: {9{sat9}}};
        vecs[3] = '{pix_kind: 2'd1, ker_kind: 2'd1, gap: 4'd3, noise: 1'b1,
                    exp: {8'd18, 8'd17, 8'd16, 8'd13, 8'd12, 8'd11, 8'd8, 8'd7, 8'd6}};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.inp_kernel = '0;
        bus.pix_valid = 1'b0;
        bus.pix_data = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pix_ready", int'(bus.pix_ready), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        rst = 1'b0;

        for (int t = 0; t < 4; t++) begin
            set_kind(vecs[t].pix_kind, vecs[t].ker_kind);
            for (int w = 0; w < NW; w++) cur_exp[w] = int'(vecs[t].exp[w]);
            run_frame($sformatf("vec%0d", t), int'(vecs[t].gap), vecs[t].noise, 0, 0);
        end

        // long sink stall on the first result
        set_kind(2'd1, 2'd1);
        for (int w = 0; w < NW; w++) cur_exp[w] = 6 + (w / 3) * 5 + (w % 3);
        run_frame("stall", 0, 1'b0, 20, 0);

        // reset in the middle of window 4
        set_kind(2'd0, 2'd0);
        send_start();
        load_frame(0, 1'b0);
        for (int w = 0; w < 4; w++) begin
            get_result(0, 1'b0, v);
            check("pre_rst_result", v, 9);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_pix_ready", int'(bus.pix_ready), 0);
        check("midrst_done", int'(bus.done), 0);
        check("midrst_out_data", int'(bus.out_data), 0);
        repeat (3) @(negedge clk);
        check("midrst_stays_idle", int'(bus.busy), 0);
        for (int w = 0; w < NW; w++) cur_exp[w] = 9;
        run_frame("post_rst", 0, 1'b0, 0, 0);

        // random frames against the arithmetic model
        for (int f = 0; f < 6; f++) begin
            for (int p = 0; p < A*A; p++) cur_pix[p] = (f % 2) ? int'($urandom_range(255, 0)) : int'($urandom_range(15, 0));
            for (int k = 0; k < C*C; k++) cur_ker[k] = (f % 2) ? int'($urandom_range(255, 0)) : int'($urandom_range(3, 0));
            model();
            run_frame($sformatf("rand%0d", f), int'($urandom_range(2, 0)), 1'b1, 0, 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
